// File: rtl/trdb_itype_detector_pipe.sv
// trdb_itype_detector_pipe: holds one retired instruction and emits its E-trace itype once the next one retires.
// Compressed-instruction classification is enabled by defining TRDB_COMPRESSED_EN.
module trdb_itype_detector_pipe #(
    parameter int XLEN      = 32,
    parameter int ITYPE_LEN = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [XLEN-1:0]      iaddr_i,
    input  logic [XLEN-1:0]      insn_i,
    input  logic                 trap_i,
    input  logic                 interrupt_i,
    input  logic                 flush_i,
    output logic                 itype_valid_o,
    input  logic                 itype_ready_i,
    output logic [ITYPE_LEN-1:0] itype_o,
    output logic [XLEN-1:0]      iaddr_o
);
    logic                 r_tc_valid;
    logic [XLEN-1:0]      r_tc_addr;
    logic [XLEN-1:0]      r_tc_insn;
    logic                 r_out_valid;
    logic [ITYPE_LEN-1:0] r_out_itype;
    logic [XLEN-1:0]      r_out_addr;
    logic                 w_xfer;
    logic                 w_emit;
    logic                 w_taken;
    logic                 w_xret;
    logic                 w_br;
    logic                 w_jalr;
    logic                 w_jal;
    logic [4:0]           w_rd;
    logic [4:0]           w_rs1;
    logic                 w_rd_link;
    logic                 w_rs1_link;
    logic [XLEN-1:0]      w_size;
    logic [3:0]           w_code;

    assign ready_o       = !r_out_valid || itype_ready_i;
    assign itype_valid_o = r_out_valid;
    assign itype_o       = r_out_itype;
    assign iaddr_o       = r_out_addr;
    assign w_xfer        = valid_i && ready_o;
    assign w_emit        = w_xfer && r_tc_valid && !flush_i;

    // Compressed forms are mapped onto the equivalent 32-bit jump/branch fields.
    always_comb begin
        w_size = XLEN'(4);
        w_rd   = r_tc_insn[11:7];
        w_rs1  = r_tc_insn[19:15];
        w_xret = r_tc_insn == 32'h30200073 || r_tc_insn == 32'h10200073 || r_tc_insn == 32'h7b200073;
        w_br   = r_tc_insn[6:0] == 7'b1100011;
        w_jalr = r_tc_insn[6:0] == 7'b1100111 && r_tc_insn[14:12] == 3'b000;
        w_jal  = r_tc_insn[6:0] == 7'b1101111;
`ifdef TRDB_COMPRESSED_EN
        if (r_tc_insn[1:0] != 2'b11) begin
            w_size = XLEN'(2);
            w_br   = r_tc_insn[1:0] == 2'b01 && r_tc_insn[15:14] == 2'b11;
            w_jal  = r_tc_insn[1:0] == 2'b01 && r_tc_insn[14:13] == 2'b01;
            w_jalr = r_tc_insn[1:0] == 2'b10 && r_tc_insn[15:13] == 3'b100 &&
                     r_tc_insn[11:7] != 5'd0 && r_tc_insn[6:2] == 5'd0;
            w_rd   = w_jal ? {4'd0, !r_tc_insn[15]} : {4'd0, r_tc_insn[12]};
            w_rs1  = r_tc_insn[11:7];
        end
`endif
        w_taken    = iaddr_i != r_tc_addr + w_size;
        w_rd_link  = w_rd == 5'd1 || w_rd == 5'd5;
        w_rs1_link = w_rs1 == 5'd1 || w_rs1 == 5'd5;
        w_code = trap_i ? (interrupt_i ? 4'd2 : 4'd1) :
                 w_xret ? 4'd3 :
                 w_br   ? (w_taken ? 4'd5 : 4'd4) :
                 w_jalr ? (ITYPE_LEN == 3 ? 4'd6 :
                           (w_rd_link && w_rs1_link && w_rd != w_rs1) ? 4'd12 :
                           w_rd_link ? 4'd8 : w_rs1_link ? 4'd13 :
                           w_rd == 5'd0 ? 4'd10 : 4'd14) :
                 w_jal  ? (ITYPE_LEN == 3 ? 4'd0 :
                           w_rd_link ? 4'd9 : w_rd == 5'd0 ? 4'd11 : 4'd15) :
                 4'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tc_valid  <= 1'b0;
            r_tc_addr   <= '0;
            r_tc_insn   <= '0;
            r_out_valid <= 1'b0;
            r_out_itype <= '0;
            r_out_addr  <= '0;
        end else begin
            if (w_xfer) begin
                r_tc_valid <= 1'b1;
                r_tc_addr  <= iaddr_i;
                r_tc_insn  <= insn_i;
            end else if (flush_i) begin
                r_tc_valid <= 1'b0;
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_itype <= w_code[ITYPE_LEN-1:0];
                r_out_addr  <= r_tc_addr;
            end else if (itype_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_trdb_itype_detector_pipe.sv
// tb_trdb_itype_detector_pipe: directed checks of itype classification, handshake, flush and reset.
module tb_trdb_itype_detector_pipe;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] CALL = 32'h000280e7;
    localparam logic [31:0] RET  = 32'h00008067;
    localparam logic [31:0] JAL0 = 32'h0000006f;
    localparam logic [31:0] MRET = 32'h30200073;
    localparam logic [31:0] CBNZ = 32'h0000e011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] iaddr_i = '0;
    logic [31:0] insn_i = '0;
    logic        trap_i = 1'b0;
    logic        interrupt_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        itype_ready_i = 1'b1;
    logic        ready_o, itype_valid_o, ready3, valid3;
    logic [3:0]  itype_o;
    logic [2:0]  itype3;
    logic [31:0] iaddr_o, iaddr3;
    int          n_vec = 0;
    int          n_err = 0;

    trdb_itype_detector_pipe #(.XLEN(32), .ITYPE_LEN(4)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .iaddr_i(iaddr_i), .insn_i(insn_i), .trap_i(trap_i), .interrupt_i(interrupt_i),
        .flush_i(flush_i), .itype_valid_o(itype_valid_o), .itype_ready_i(itype_ready_i),
        .itype_o(itype_o), .iaddr_o(iaddr_o));

    trdb_itype_detector_pipe #(.XLEN(32), .ITYPE_LEN(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready3),
        .iaddr_i(iaddr_i), .insn_i(insn_i), .trap_i(trap_i), .interrupt_i(interrupt_i),
        .flush_i(flush_i), .itype_valid_o(valid3), .itype_ready_i(itype_ready_i),
        .itype_o(itype3), .iaddr_o(iaddr3));

    always #5 clk = ~clk;

    task automatic send(input logic [31:0] a, input logic [31:0] w, input logic t, input logic irq);
        valid_i = 1'b1; iaddr_i = a; insn_i = w; trap_i = t; interrupt_i = irq;
        @(posedge clk); #1;
        valid_i = 1'b0; trap_i = 1'b0; interrupt_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (itype_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", itype_valid_o); end
        n_vec++; if (itype_o !== 4'd0) begin n_err++; $display("FAIL rst_itype got %0d want 0", itype_o); end
        n_vec++; if (iaddr_o !== 32'h0) begin n_err++; $display("FAIL rst_iaddr got %h want 0", iaddr_o); end
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", ready_o); end
        rst = 1'b0;
    endtask

    task automatic test_branch;
        send(32'h100, BEQ, 0, 0);
        n_vec++; if (itype_valid_o !== 1'b0) begin n_err++; $display("FAIL first_load got valid %b want 0", itype_valid_o); end
        send(32'h108, NOP, 0, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd5, 32'h100}) begin n_err++; $display("FAIL br_taken got %b/%0d/%h want 1/5/100", itype_valid_o, itype_o, iaddr_o); end
        send(32'h10c, BEQ, 0, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd0, 32'h108}) begin n_err++; $display("FAIL plain got %b/%0d/%h want 1/0/108", itype_valid_o, itype_o, iaddr_o); end
        send(32'h110, NOP, 0, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd4, 32'h10c}) begin n_err++; $display("FAIL br_not_taken got %b/%0d/%h want 1/4/10c", itype_valid_o, itype_o, iaddr_o); end
    endtask

    task automatic test_call;
        send(32'h200, CALL, 0, 0);
        send(32'h204, NOP, 0, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd12, 32'h200}) begin n_err++; $display("FAIL call4 got %b/%0d/%h want 1/12/200", itype_valid_o, itype_o, iaddr_o); end
        n_vec++; if ({valid3, itype3, iaddr3} !== {1'b1, 3'd6, 32'h200}) begin n_err++; $display("FAIL call3 got %b/%0d/%h want 1/6/200", valid3, itype3, iaddr3); end
    endtask

    task automatic test_return;
        send(32'h208, RET, 0, 0);
        send(32'h40, NOP, 0, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd13, 32'h208}) begin n_err++; $display("FAIL ret4 got %b/%0d/%h want 1/13/208", itype_valid_o, itype_o, iaddr_o); end
        n_vec++; if (itype3 !== 3'd6) begin n_err++; $display("FAIL ret3 got %0d want 6", itype3); end
        send(32'h44, JAL0, 0, 0);
        send(32'h44, NOP, 0, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd11, 32'h44}) begin n_err++; $display("FAIL jal0_4 got %b/%0d/%h want 1/11/44", itype_valid_o, itype_o, iaddr_o); end
        n_vec++; if ({valid3, itype3} !== {1'b1, 3'd0}) begin n_err++; $display("FAIL jal0_3 got %b/%0d want 1/0", valid3, itype3); end
    endtask

    task automatic test_trap;
        send(32'h300, BEQ, 0, 0);
        send(32'h80, NOP, 1, 1);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd2, 32'h300}) begin n_err++; $display("FAIL trap_irq got %b/%0d/%h want 1/2/300", itype_valid_o, itype_o, iaddr_o); end
        n_vec++; if (itype3 !== 3'd2) begin n_err++; $display("FAIL trap_irq3 got %0d want 2", itype3); end
        send(32'h90, NOP, 1, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd1, 32'h80}) begin n_err++; $display("FAIL trap_exc got %b/%0d/%h want 1/1/80", itype_valid_o, itype_o, iaddr_o); end
    endtask

    task automatic test_backpressure;
        itype_ready_i = 1'b0;
        valid_i = 1'b1; iaddr_i = 32'h94; insn_i = NOP;
        #1;
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", ready_o); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd1, 32'h80}) begin n_err++; $display("FAIL bp_hold%0d got %b/%0d/%h want 1/1/80", k, itype_valid_o, itype_o, iaddr_o); end
            n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d got %b want 0", k, ready_o); end
        end
        itype_ready_i = 1'b1;
        #1;
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_release got %b want 1", ready_o); end
        @(posedge clk); #1;
        valid_i = 1'b0;
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd0, 32'h90}) begin n_err++; $display("FAIL bp_drain got %b/%0d/%h want 1/0/90", itype_valid_o, itype_o, iaddr_o); end
        @(posedge clk); #1;
        n_vec++; if (itype_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_fall got %b want 0", itype_valid_o); end
        send(32'h98, NOP, 0, 0);
        n_vec++; if ({itype_valid_o, iaddr_o} !== {1'b1, 32'h94}) begin n_err++; $display("FAIL bp_kept got %b/%h want 1/94", itype_valid_o, iaddr_o); end
    endtask

    task automatic test_flush_reset;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        n_vec++; if (itype_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_idle got %b want 0", itype_valid_o); end
        send(32'h500, NOP, 0, 0);
        n_vec++; if (itype_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_drop got %b want 0", itype_valid_o); end
        flush_i = 1'b1;
        send(32'h600, BEQ, 0, 0);
        n_vec++; if (itype_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_xfer got %b want 0", itype_valid_o); end
        send(32'h604, NOP, 0, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd4, 32'h600}) begin n_err++; $display("FAIL flush_reload got %b/%0d/%h want 1/4/600", itype_valid_o, itype_o, iaddr_o); end
        send(32'h700, NOP, 0, 0);
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b0, 4'd0, 32'h0}) begin n_err++; $display("FAIL async_rst got %b/%0d/%h want 0/0/0", itype_valid_o, itype_o, iaddr_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        send(32'h800, NOP, 0, 0);
        n_vec++; if (itype_valid_o !== 1'b0) begin n_err++; $display("FAIL post_rst got %b want 0", itype_valid_o); end
    endtask

    task automatic test_compressed;
        logic [3:0] exp;
`ifdef TRDB_COMPRESSED_EN
        exp = 4'd4;
`else
        exp = 4'd0;
`endif
        send(32'h400, CBNZ, 0, 0);
        send(32'h402, NOP, 0, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, exp, 32'h400}) begin n_err++; $display("FAIL cbnez got %b/%0d/%h want 1/%0d/400", itype_valid_o, itype_o, iaddr_o, exp); end
    endtask

    task automatic test_back_to_back;
        send(32'h1000, MRET, 0, 0);
        send(32'h2000, NOP, 0, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd3, 32'h1000}) begin n_err++; $display("FAIL mret got %b/%0d/%h want 1/3/1000", itype_valid_o, itype_o, iaddr_o); end
        send(32'h2004, CALL, 0, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd0, 32'h2000}) begin n_err++; $display("FAIL b2b_nop got %b/%0d/%h want 1/0/2000", itype_valid_o, itype_o, iaddr_o); end
        send(32'h3000, NOP, 0, 0);
        n_vec++; if ({itype_valid_o, itype_o, iaddr_o} !== {1'b1, 4'd12, 32'h2004}) begin n_err++; $display("FAIL b2b_call got %b/%0d/%h want 1/12/2004", itype_valid_o, itype_o, iaddr_o); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call();
        test_return();
        test_trap();
        test_backpressure();
        test_flush_reset();
        test_compressed();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/trdb_itype_detector_pipe.md
# trdb_itype_detector_pipe

Pipelined, parametrised instruction-type classifier for the trace encoder. It accepts one retired instruction per cycle and holds it internally until the next one retires, so branch-taken status and trap information are resolved without external staging. It then emits the E-trace `itype` code for the held instruction through a valid/ready handshake to the packet-emitter stage. It supersedes the combinational branch/updiscon detector and adds call, return, tail, swap and exception-return classification.

## Interface
- `XLEN`, default 32: address and instruction width; only 32 is supported.
- `ITYPE_LEN`, default 4: width of the itype code; legal values are 3 or 4.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset; asynchronous, active-high.
- `valid_i` input 1: an instruction retired this cycle.
- `ready_o` output 1: the block can accept `valid_i`.
- `iaddr_i` input XLEN: retired instruction address.
- `insn_i` input XLEN: retired instruction word. For compressed instructions, bits [15:0] hold the instruction.
- `trap_i` input 1: qualified by `valid_i`; this instruction is the first of a trap handler.
- `interrupt_i` input 1: qualified by `trap_i`; the trap is an interrupt rather than an exception.
- `flush_i` input 1: discard the held instruction; no output is produced for it.
- `itype_valid_o` output 1: output bundle is valid.
- `itype_ready_i` input 1: downstream accepts the bundle.
- `itype_o` output ITYPE_LEN: itype of the held (tc) instruction.
- `iaddr_o` output XLEN: address of the classified instruction.

## Operation
- Holding register (tc) stores {valid, addr, insn, size}; size is 2 if `insn[1:0]!=2'b11` and compressed support is on, otherwise 4.
- A transfer (`valid_i && ready_o`) while tc is valid produces a new output for tc, then loads tc from the inputs. If tc is empty, the transfer only loads tc.
- Taken is defined as `iaddr_i != tc.addr + size`, computed modulo 2^XLEN.
- itype priority, highest first:
  - `trap_i` gives 2 if `interrupt_i` is set, else 1.
  - tc insn is mret 0x30200073, sret 0x10200073 or dret 0x7b200073: 3.
  - Conditional branch (opcode 1100011): 5 if taken, else 4.
  - jalr (opcode 1100111, funct3 000): rules below.
  - jal (opcode 1101111): rules below.
  - Anything else: 0.
- Link registers are x1 and x5.
- Jump codes for ITYPE_LEN=4:
  - jalr, rd link, rs1 link, rd≠rs1: 12.
  - jalr, rd link otherwise: 8.
  - jalr, rs1 link, rd not link: 13.
  - jalr, rd=x0: 10.
  - jalr, other: 14.
  - jal, rd link: 9.
  - jal, rd=x0: 11.
  - jal, other: 15.
- Jump codes for ITYPE_LEN=3: every jalr gives 6; every jal gives 0.
- `ready_o = !itype_valid_o || itype_ready_i`.
- Output registers hold their value while `itype_valid_o && !itype_ready_i`.
- `flush_i` clears tc.valid. It has priority over a simultaneous transfer's output generation: with flush and transfer in the same cycle, tc is loaded from the inputs but no output is produced. The output register is not affected by `flush_i`.

## Timing
- Reset: `itype_valid_o`=0, `itype_o`=0, `iaddr_o`=0, tc.valid=0. `ready_o` is therefore 1.
- Latency: the output is registered. `itype_valid_o` rises on the clock edge that accepts the next instruction after tc.
- Throughput is one instruction per cycle while `itype_ready_i` is held high.
- `itype_valid_o` falls on the edge where `itype_ready_i` is high and no new output is produced.
- Reset asserted mid-operation clears tc and the output immediately, asynchronously. The instruction in flight is lost.

## Configuration
- `TRDB_COMPRESSED_EN` defined:
  - size follows `insn[1:0]`.
  - c.beqz/c.bnez (q01, funct3 110/111) classify as branch.
  - c.j (q01, funct3 101) classifies as jal rd=x0.
  - c.jal (q01, funct3 001) classifies as jal rd=x1.
  - c.jr (q10, funct4 1000, rs1≠0, rs2=0) classifies as jalr rd=x0.
  - c.jalr (q10, funct4 1001, rs1≠0, rs2=0) classifies as jalr rd=x1.
- `TRDB_COMPRESSED_EN` undefined: size is always 4, and compressed encodings classify as 0.

## Test plan
- Taken branch: beq 0x00208463 at 0x100, then next instruction at 0x108 → one cycle later itype 5, `iaddr_o`=0x100. Same beq followed by 0x104 → itype 4.
- Call: jalr x1,0(x5) 0x000280e7 at 0x200 → itype 12 with ITYPE_LEN=4; itype 6 with ITYPE_LEN=3.
- Return: ret 0x00008067 → itype 13. jal x0 0x0000006f → itype 11 with ITYPE_LEN=4; itype 0 with ITYPE_LEN=3.
- Trap priority: beq at 0x300, next `valid_i` with `trap_i`=1, `interrupt_i`=1 at 0x80 → itype 2, not 5.
- Backpressure: `itype_ready_i`=0 for 3 cycles with valid_i held → output stable, `ready_o`=0, no instruction lost. Release → outputs drain in order.
- Compressed, with `TRDB_COMPRESSED_EN`: c.bnez 0xe011 at 0x400, next instruction at 0x402 → itype 4. Without the macro, the same stimulus gives itype 0. Assert `flush_i` then reset mid-stream → no spurious `itype_valid_o`.
